// File: rtl/sigmoid_backward_pkg.sv
// -----------------------------------------------------------------------------
// sigmoid_backward_pkg
//
// Shared Q8.24 fixed-point definitions for the sigmoid backward-pass unit.
//   DATA_W / FRAC_W : total signed width and fractional bit count.
//   ONE / ZERO      : the constants 1.0 and 0.0 in Q8.24.
//   state_t         : sequencing FSM states (IDLE -> MUL1 -> MUL2 -> DONE).
//   clamp01()       : saturate a Q8.24 value into the closed range [0, ONE].
// -----------------------------------------------------------------------------
package sigmoid_backward_pkg;

    localparam int DATA_W = 32;
    localparam int FRAC_W = 24;

    localparam logic signed [DATA_W-1:0] ONE  = 32'sh0100_0000;
    localparam logic signed [DATA_W-1:0] ZERO = 32'sh0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL1 = 2'd1,
        MUL2 = 2'd2,
        DONE = 2'd3
    } state_t;

    // A stored activation should already lie in [0, 1], but the value may have
    // been corrupted or produced by a differently-rounded forward unit.
    // Clamping keeps y*(1-y) non-negative and bounded by 0.25.
    function automatic logic signed [DATA_W-1:0] clamp01(
        input logic signed [DATA_W-1:0] v
    );
        logic signed [DATA_W-1:0] r;
        r = v;
        if (v < ZERO) begin
            r = ZERO;
        end else if (v > ONE) begin
            r = ONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/sigmoid_backward_fxp_mul.sv
// -----------------------------------------------------------------------------
// fxp_mul
//
// Combinational signed Q8.24 multiply. The full 2*DATA_W-bit product is
// shifted arithmetically right by FRAC_W (floor rounding), and the low
// DATA_W bits of that shifted value are returned.
//
// Ports:
//   a, b : signed Q8.24 operands
//   p    : signed Q8.24 result, floor((a*b) / 2^FRAC_W) truncated to DATA_W
// -----------------------------------------------------------------------------
module fxp_mul
    import sigmoid_backward_pkg::*;
(
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] p
);

    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0] full;
    logic                 unused_bits;

    // Sign-extend both operands to the full product width before multiplying.
    assign full = PW'(a) * PW'(b);

    // Taking bits [FRAC_W +: DATA_W] of the product is exactly the low DATA_W
    // bits of (full >>> FRAC_W); the discarded bits are floored away.
    assign p = full[FRAC_W +: DATA_W];

    assign unused_bits = ^{full[FRAC_W-1:0], full[PW-1:FRAC_W+DATA_W]};

endmodule

// File: rtl/sigmoid_backward.sv
// -----------------------------------------------------------------------------
// sigmoid_backward
//
// Backward pass of the Q8.24 sigmoid: grad_out = g * y * (1 - y), with y the
// stored forward activation (clamped to [0, 1]) and g the upstream gradient.
// One shared multiplier is used twice, sequenced by a four-state FSM.
//
// Handshakes (both sides): a transfer happens on a rising clock edge where
// valid && ready are both high. A source holds valid and its data stable until
// that edge; the sink may drive ready regardless of valid. Here in_ready is
// high only in IDLE, and out_valid/grad_out are held from DONE entry until the
// output transfer.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : input pair (y_in, grad_in) presented
//   in_ready   : unit is in IDLE and will accept an input pair
//   y_in       : forward sigmoid output, signed Q8.24
//   grad_in    : upstream gradient, signed Q8.24
//   out_valid  : grad_out holds a result
//   out_ready  : downstream accepts the result
//   grad_out   : local gradient, signed Q8.24
//   busy       : FSM is not in IDLE
//   state_dbg  : current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module sigmoid_backward
    import sigmoid_backward_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] y_in,
    input  logic [DATA_W-1:0] grad_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] grad_out,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    state_t                   state_q, state_d;
    logic signed [DATA_W-1:0] y_q, y_d;        // clamped activation
    logic signed [DATA_W-1:0] g_q, g_d;        // upstream gradient
    logic signed [DATA_W-1:0] p_q, p_d;        // y * (1 - y), in [0, 0.25]
    logic signed [DATA_W-1:0] grad_q, grad_d;  // result register
    logic                     out_valid_q, out_valid_d;

    logic signed [DATA_W-1:0] mul_a;
    logic signed [DATA_W-1:0] mul_b;
    logic signed [DATA_W-1:0] mul_p;

    // Operand mux for the single shared multiplier: MUL2 forms g * p, every
    // other state presents y * (1 - y), which only MUL1 actually stores.
    always_comb begin
        mul_a = y_q;
        mul_b = ONE - y_q;
        if (state_q == MUL2) begin
            mul_a = g_q;
            mul_b = p_q;
        end
    end

    fxp_mul u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        g_d         = g_q;
        p_d         = p_q;
        grad_d      = grad_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    y_d     = clamp01(y_in);
                    g_d     = grad_in;
                    state_d = MUL1;
                end
            end
            MUL1: begin
                p_d     = mul_p;
                state_d = MUL2;
            end
            MUL2: begin
                // |g * p| <= 128 * 0.25, so the DATA_W-bit result cannot wrap.
                grad_d      = mul_p;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                // A new in_valid here is deliberately not looked at; the
                // source keeps it up and it is taken once back in IDLE.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            y_q         <= '0;
            g_q         <= '0;
            p_q         <= '0;
            grad_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            g_q         <= g_d;
            p_q         <= p_d;
            grad_q      <= grad_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign grad_out  = grad_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sigmoid_backward.sv
// -----------------------------------------------------------------------------
// tb_sigmoid_backward
//
// Bench for sigmoid_backward: fixed vector table, randomized transactions
// against a plain-arithmetic reference, backpressure and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_sigmoid_backward;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y_in;
  logic [31:0] grad_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] grad_out;
  logic        busy;
  logic [1:0]  state_dbg;

  int checks;
  int failures;

  sigmoid_backward dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_in      (y_in),
    .grad_in   (grad_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grad_out  (grad_out),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] y;
    logic [31:0] g;
    logic [31:0] exp;
  } vec_t;

  localparam longint ONE_R = 64'sd16777216;

  // Reference: grad = floor(g * floor(yc * (1 - yc))) with yc = clamp(y, 0, 1),
  // all quantities as integers scaled by 2^24.
  function automatic logic [31:0] ref_grad(input logic [31:0] y, input logic [31:0] g);
    longint yv, gv, yc, p, r;
    yv = longint'($signed(y));
    gv = longint'($signed(g));
    if (yv < 0) yc = 0;
    else if (yv > ONE_R) yc = ONE_R;
    else yc = yv;
    p = (yc * (ONE_R - yc)) >>> 24;
    r = (gv * p) >>> 24;
    return r[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_in(input logic [31:0] y, input logic [31:0] g);
    @(negedge clk);
    in_valid = 1'b1;
    y_in     = y;
    grad_in  = g;
  endtask

  // Called at a negedge with in_valid up; returns at the negedge after the
  // accepting edge, with in_valid dropped.
  task automatic wait_accept(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({name, "_accept_timeout"}, 32'(ok), 32'd1);
  endtask

  // Latency counts edges with the accepting edge as 1.
  task automatic wait_result(output logic [31:0] res, output int lat);
    lat = 1;
    res = 'x;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) begin
        res = grad_out;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_txn(input string name, input logic [31:0] y, input logic [31:0] g,
                         input logic [31:0] exp);
    logic [31:0] res;
    int lat;
    drive_in(y, g);
    wait_accept(name);
    wait_result(res, lat);
    chk({name, "_grad"}, res, exp);
    chk({name, "_latency"}, 32'(lat), 32'd3);
    chk({name, "_in_ready_done"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    chk({name, "_out_valid_clear"}, 32'(out_valid), 32'd0);
    chk({name, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  vec_t vecs[8];

  initial begin
    logic [31:0] res;
    logic [31:0] ry;
    logic [31:0] rg;
    int          lat;
    logic [31:0] exp_q[$];

    checks    = 0;
    failures  = 0;
    in_valid  = 1'b0;
    y_in      = '0;
    grad_in   = '0;
    out_ready = 1'b1;
    rst       = 1'b1;

    vecs[0] = '{32'h0080_0000, 32'h0100_0000, 32'h0040_0000};
    vecs[1] = '{32'h00C0_0000, 32'hFE00_0000, 32'hFFA0_0000};
    vecs[2] = '{32'h0100_0000, 32'h0100_0000, 32'h0000_0000};
    vecs[3] = '{32'h0000_0000, 32'h0100_0000, 32'h0000_0000};
    vecs[4] = '{32'h0180_0000, 32'h0100_0000, 32'h0000_0000};
    vecs[5] = '{32'hFF00_0000, 32'h0100_0000, 32'h0000_0000};
    vecs[6] = '{32'h0080_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[7] = '{32'h0080_0000, 32'h0000_0001, 32'h0000_0000};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_grad_out", grad_out, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // table vectors
    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].y, vecs[i].g, vecs[i].exp);
    end

    // randomized transactions
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: ry = $urandom();
        1: ry = 32'h0100_0000 - 32'($urandom_range(0, 3));
        default: ry = 32'($urandom_range(0, 32'h0100_0000));
      endcase
      rg = $urandom();
      exp_q.push_back(ref_grad(ry, rg));
      run_txn($sformatf("rand%0d", i), ry, rg, exp_q.pop_front());
    end

    // backpressure: result held, pending input not taken
    out_ready = 1'b0;
    drive_in(32'h00C0_0000, 32'hFE00_0000);
    wait_accept("bp");
    wait_result(res, lat);
    chk("bp_grad", res, 32'hFFA0_0000);
    in_valid = 1'b1;
    y_in     = 32'h0080_0000;
    grad_in  = 32'h0100_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold%0d_grad", i), grad_out, 32'hFFA0_0000);
      chk($sformatf("bp_hold%0d_in_ready", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    wait_accept("bp_pending");
    wait_result(res, lat);
    chk("bp_pending_grad", res, 32'h0040_0000);
    chk("bp_pending_latency", 32'(lat), 32'd3);
    @(negedge clk);

    // reset while in MUL2; grad_out still shows the previous 0x00400000
    drive_in(32'h00C0_0000, 32'h0100_0000);
    wait_accept("mr");
    @(negedge clk);
    chk("mr_busy_before", 32'(busy), 32'd1);
    chk("mr_grad_before", grad_out, 32'h0040_0000);
    #1 rst = 1'b1;
    #1;
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_grad_out", grad_out, 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    run_txn("mr_next", 32'h0080_0000, 32'h0100_0000, 32'h0040_0000);

    // back-to-back throughput: 4 cycles per result with out_ready high
    drive_in(32'h0040_0000, 32'h0200_0000);
    wait_accept("tp0");
    wait_result(res, lat);
    chk("tp0_grad", res, ref_grad(32'h0040_0000, 32'h0200_0000));
    in_valid = 1'b1;
    y_in     = 32'h0080_0000;
    grad_in  = 32'hFF00_0000;
    wait_accept("tp1");
    wait_result(res, lat);
    chk("tp1_grad", res, 32'hFFC0_0000);
    chk("tp1_latency", 32'(lat), 32'd3);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sigmoid_backward.md
Name: sigmoid_backward

Overview:
- Backward-pass companion to the Q8.24 piecewise-linear sigmoid unit.
- Takes a stored forward activation y = sigmoid(x) and an upstream gradient g, and returns the local gradient g·y·(1−y).
- Sits in the training datapath between the loss/gradient stream and the weight-update logic.
- Uses one shared signed multiplier, sequenced by a small FSM, with valid/ready handshakes on both sides.

Parameters:
- DATA_W, 32, total signed fixed-point width (Q8.24 format).
- FRAC_W, 24, fractional bits. ONE = 1 << FRAC_W = 0x01000000.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  an input pair is presented.
- in_ready  out  1  block can accept an input pair.
- y_in  in  DATA_W  forward sigmoid output, signed Q8.24.
- grad_in  in  DATA_W  upstream gradient, signed Q8.24.
- out_valid  out  1  grad_out holds a result.
- out_ready  in  1  downstream accepts the result.
- grad_out  out  DATA_W  local gradient, signed Q8.24.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values (asynchronous, take effect immediately): state = IDLE, out_valid = 0, grad_out = 0, all internal registers = 0. in_ready = 1 once rst is deasserted. busy = 0.
- States: IDLE → MUL1 → MUL2 → DONE → IDLE.
- in_ready = (state == IDLE). This is the only state in which inputs are accepted.
- busy = (state != IDLE).
- IDLE: on in_valid && in_ready at edge T:
  - register y_c = clamp(y_in, 0, ONE): negative values become 0, values above ONE become ONE.
  - register g = grad_in.
  - go to MUL1.
- MUL1 (edge T+1): p = (y_c · (ONE − y_c)) >>> FRAC_W. Full 2·DATA_W-bit signed product, arithmetic shift (floor). Go to MUL2.
- MUL2 (edge T+2): grad_out = ((g · p) >>> FRAC_W), keeping the low DATA_W bits; set out_valid = 1; go to DONE.
- Overflow is impossible because 0 ≤ p ≤ 0x00400000 (0.25). No saturation logic is required.
- Latency: out_valid is high in the cycle after edge T+2, i.e. 3 cycles after the input handshake.
- DONE:
  - grad_out and out_valid are held stable until out_valid && out_ready.
  - On that edge, out_valid is cleared and the FSM returns to IDLE.
  - in_ready rises in the following cycle.
- Throughput: one result per 4 cycles when out_ready is held high.
- in_valid asserted outside IDLE is ignored; the input is not captured and the source must hold it.
- Simultaneous out handshake and new in_valid in DONE: the new input is not accepted that cycle. It is accepted in IDLE on the next edge.
- Reset mid-operation: the in-flight result is discarded; all outputs and state return to their reset values.
- Rounding: floor (arithmetic shift) at both multiply stages. No rounding increment.

Decomposition:
- Shared fixed-point package holds:
  - DATA_W, FRAC_W.
  - the ONE and ZERO constants in Q8.24.
  - the FSM state enum {IDLE, MUL1, MUL2, DONE}.
  - a clamp01 function.
- One natural sub-module: fxp_mul, a combinational signed Q8.24 multiply with arithmetic shift by FRAC_W. It is instantiated once; its operands are muxed by state.

Test Plan:
- y = 0x00800000 (0.5), g = 0x01000000 (1.0) → grad_out = 0x00400000 (0.25). out_valid rises exactly 3 cycles after the handshake.
- y = 0x00C00000 (0.75), g = 0xFE000000 (−2.0) → p = 0x00300000; grad_out = 0xFFA00000 (−0.375).
- Clamp and edge cases, g = 0x01000000 in each case:
  - y = 0x01000000 → 0x00000000.
  - y = 0x00000000 → 0x00000000.
  - y = 0x01800000 (1.5) → 0x00000000.
  - y = 0xFF000000 (−1.0) → 0x00000000.
- Floor rounding: y = 0x00800000, g = 0xFFFFFFFF (−1 LSB) → grad_out = 0xFFFFFFFF. With g = 0x00000001 → grad_out = 0x00000000.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid.
  - grad_out and out_valid stay stable; in_ready stays 0; a pending in_valid is not taken.
  - After out_ready = 1, in_ready = 1 on the next cycle and the pending input is accepted.
- Reset mid-operation: assert rst in MUL2.
  - Outputs clear immediately (out_valid = 0, grad_out = 0, busy = 0).
  - After release, in_ready = 1 and the next transaction (y = 0.5, g = 1.0) returns 0x00400000.
